bsg_chip_link_bist: RTL and testbench



---
 rtl/bsg_chip_link_bist.sv | 131 +++++++++++++
 tb/tb_bsg_chip_link_bist.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_chip_link_bist.sv
// BIST engine for one chip-IO ready/valid link: transmits seed+k, checks received words against the same sequence.
// Optional `BSG_CHIP_LINK_BIST_ERR_INJECT_EN adds inject_i to flip bit 0 of the next transmitted word.
module bsg_chip_link_bist #(
  parameter int unsigned width_p       = 64,
  parameter int unsigned count_width_p = 16,
  parameter int unsigned timeout_p     = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic [count_width_p-1:0] num_packets_i,
  input  logic [width_p-1:0]       seed_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     ready_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     timeout_o,
  output logic [count_width_p-1:0] rx_count_o,
  output logic [count_width_p-1:0] err_count_o,
  output logic [count_width_p-1:0] first_err_idx_o
`ifdef BSG_CHIP_LINK_BIST_ERR_INJECT_EN
  ,
  input  logic                     inject_i
`endif
);

  localparam int unsigned idle_width_lp = $clog2(timeout_p);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                   state, state_next;
  logic [width_p-1:0]       seed;
  logic [count_width_p-1:0] num;
  logic [count_width_p-1:0] tx_k;
  logic [idle_width_lp-1:0] idle_cnt;
  logic                     rx_over;
  logic                     tx_flip;

  logic start_ok, tx_hs, rx_hs, tx_last, idle_expired, rx_all, rx_bad;

  assign start_ok     = start_i && (state == IDLE || state == DONE);
  assign tx_hs        = v_o && ready_i;
  assign rx_hs        = v_i && ready_o;
  assign tx_last      = (tx_k == num - count_width_p'(1));
  assign idle_expired = (idle_cnt == idle_width_lp'(timeout_p - 1));
  assign rx_all       = (rx_count_o == num);
  // A word arriving after the full count has been received is an error even if its value matches.
  assign rx_bad       = rx_over || (data_i != seed + width_p'(rx_count_o));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_i) state_next = (num_packets_i == '0) ? DONE : RUN;
      RUN:        if (tx_hs && tx_last) state_next = DRAIN;
      DRAIN: begin
        if (rx_all)                     state_next = DONE;
        else if (!rx_hs && idle_expired) state_next = DONE;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    v_o     = (state == RUN);
    ready_o = (state == RUN) || (state == DRAIN);
    busy_o  = (state == RUN) || (state == DRAIN);
    done_o  = (state == DONE);
  end

  assign data_o = (seed + width_p'(tx_k)) ^ {{(width_p-1){1'b0}}, tx_flip};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      seed            <= '0;
      num             <= '0;
      tx_k            <= '0;
      rx_count_o      <= '0;
      err_count_o     <= '0;
      first_err_idx_o <= '1;
      timeout_o       <= 1'b0;
      rx_over         <= 1'b0;
      idle_cnt        <= '0;
    end else if (start_ok) begin
      seed            <= seed_i;
      num             <= num_packets_i;
      tx_k            <= '0;
      rx_count_o      <= '0;
      err_count_o     <= '0;
      first_err_idx_o <= '1;
      timeout_o       <= 1'b0;
      rx_over         <= 1'b0;
      idle_cnt        <= '0;
    end else begin
      if (tx_hs) tx_k <= tx_k + count_width_p'(1);
      if (rx_hs) begin
        rx_count_o <= rx_count_o + count_width_p'(1);
        if (rx_count_o + count_width_p'(1) == num) rx_over <= 1'b1;
        if (rx_bad) begin
          if (err_count_o != '1) err_count_o <= err_count_o + count_width_p'(1);
          if (err_count_o == '0) first_err_idx_o <= rx_count_o;
        end
      end
      // Idle cycles also accumulate in RUN so a stall straddling the RUN->DRAIN edge is measured in full.
      if (rx_hs)                      idle_cnt <= '0;
      else if (busy_o && !idle_expired) idle_cnt <= idle_cnt + idle_width_lp'(1);
      if (state == DRAIN && !rx_all && !rx_hs && idle_expired) timeout_o <= 1'b1;
    end
  end

`ifdef BSG_CHIP_LINK_BIST_ERR_INJECT_EN
  logic armed;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)          armed <= 1'b0;
    else if (tx_hs && armed) armed <= 1'b0;
    else if (inject_i)       armed <= 1'b1;
  end
  assign tx_flip = armed;
`else
  assign tx_flip = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_chip_link_bist.sv
// Self-checking bench for bsg_chip_link_bist: tx looped to rx with optional drop/corrupt and random tx stalls.
module tb_bsg_chip_link_bist;
  localparam int W  = 64;
  localparam int C  = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [C-1:0] num = '0;
  logic [W-1:0] seed = '0;
  logic ready_i = 1'b1;
  logic v_o, ready_o, busy, done, tmo, v_i;
  logic [W-1:0] data_o, data_i;
  logic [C-1:0] rx_count, err_count, first_idx;
`ifdef BSG_CHIP_LINK_BIST_ERR_INJECT_EN
  logic inject = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int tx_idx = 0;
  int drop_idx = -1;
  int corrupt_idx = -1;
  bit rand_ready = 1'b0;
  int done_cyc;
  int tx_hs_n;
  int rx_cyc[$];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign v_i    = v_o && ready_i && (tx_idx != drop_idx);
  assign data_i = data_o ^ ((tx_idx == corrupt_idx) ? 64'h8 : 64'h0);

  bsg_chip_link_bist #(.width_p(W), .count_width_p(C), .timeout_p(TO)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .num_packets_i(num), .seed_i(seed),
    .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .busy_o(busy), .done_o(done), .timeout_o(tmo),
    .rx_count_o(rx_count), .err_count_o(err_count), .first_err_idx_o(first_idx)
`ifdef BSG_CHIP_LINK_BIST_ERR_INJECT_EN
    , .inject_i(inject)
`endif
  );

  task automatic start_test(input logic [W-1:0] s, input logic [C-1:0] n);
    @(negedge clk);
    seed = s; num = n; start = 1'b1;
    exp_q.delete();
    for (int k = 0; k < int'(n); k++) exp_q.push_back(s + W'(k));
    @(posedge clk); #1;
    start = 1'b0;
    tx_idx = 0;
  endtask

  // Runs until done_o, checking every tx word against the scoreboard and data hold during stalls.
  task automatic run(input int max_cycles);
    bit hs;
    bit stalled;
    logic [W-1:0] held, e;
    stalled = 1'b0; held = '0;
    done_cyc = -1; tx_hs_n = 0; rx_cyc.delete();
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (done) begin done_cyc = c; break; end
      if (stalled) begin
        total++;
        if (data_o !== held) begin bad++; $display("FAIL stall_hold: data_o=%h required %h", data_o, held); end
      end
      stalled = v_o && !ready_i;
      held = data_o;
      hs = v_o && ready_i;
      if (hs) begin
        total++;
        tx_hs_n++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL tx_extra: data_o=%h required no word", data_o);
        end else begin
          e = exp_q.pop_front();
          if (data_o !== e) begin bad++; $display("FAIL tx_word: data_o=%h required %h", data_o, e); end
        end
      end
      if (v_i && ready_o) rx_cyc.push_back(c);
      @(posedge clk); #1;
      if (hs) tx_idx++;
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    total++;
    if (done_cyc < 0) begin bad++; $display("FAIL done_wait: done_o=%b required 1 within %0d cycles", done, max_cycles); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL tx_remaining: %0d words unsent required 0", exp_q.size()); end
  endtask

  task automatic check_status(input string name, input logic t, input logic [C-1:0] rc,
                              input logic [C-1:0] ec, input logic [C-1:0] fi);
    total++;
    if ({done, busy, tmo, rx_count, err_count, first_idx} !== {1'b1, 1'b0, t, rc, ec, fi}) begin
      bad++;
      $display("FAIL %s: done=%b busy=%b tmo=%b rx=%h err=%h first=%h required done=1 busy=0 tmo=%b rx=%h err=%h first=%h",
               name, done, busy, tmo, rx_count, err_count, first_idx, t, rc, ec, fi);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({v_o, ready_o, busy, done, tmo} !== 5'b0 || data_o !== '0) begin
      bad++; $display("FAIL reset_ctrl: v=%b rdy=%b busy=%b done=%b tmo=%b data=%h required all 0", v_o, ready_o, busy, done, tmo, data_o);
    end
    total++;
    if ({rx_count, err_count, first_idx} !== {16'h0, 16'h0, 16'hFFFF}) begin
      bad++; $display("FAIL reset_counts: rx=%h err=%h first=%h required 0 0 ffff", rx_count, err_count, first_idx);
    end
  endtask

  task automatic test_loopback;
    rand_ready = 1'b0; ready_i = 1'b1;
    start_test(64'h10, 16'd8);
    total++;
    if ({v_o, busy} !== 2'b11 || data_o !== 64'h10) begin
      bad++; $display("FAIL start_timing: v=%b busy=%b data=%h required 1 1 10", v_o, busy, data_o);
    end
    run(100);
    check_status("loopback_status", 1'b0, 16'd8, 16'd0, 16'hFFFF);
    // done_o is seen two cycles after the final rx handshake (counter update, then DONE).
    total++;
    if (rx_cyc.size() != 8 || done_cyc - rx_cyc[rx_cyc.size()-1] != 2) begin
      bad++; $display("FAIL done_latency: rx_hs=%0d gap=%0d required 8 and 2", rx_cyc.size(),
                      rx_cyc.size() ? done_cyc - rx_cyc[rx_cyc.size()-1] : -1);
    end
  endtask

  task automatic test_back_to_back;
    rand_ready = 1'b0; ready_i = 1'b1;
    start_test(64'hFFFF_FFFF_FFFF_FFFE, 16'd5);
    run(100);
    total++;
    if (tx_hs_n != 5 || rx_cyc.size() != 5 || rx_cyc[4] - rx_cyc[0] != 4) begin
      bad++; $display("FAIL back_to_back: tx=%0d rx=%0d span=%0d required 5 5 4", tx_hs_n, rx_cyc.size(),
                      rx_cyc.size() == 5 ? rx_cyc[4] - rx_cyc[0] : -1);
    end
    check_status("wrap_status", 1'b0, 16'd5, 16'd0, 16'hFFFF);
  endtask

  task automatic test_stalls;
    rand_ready = 1'b1;
    start_test(64'h1234_5678_9ABC_DEF0, 16'd100);
    run(2000);
    rand_ready = 1'b0; ready_i = 1'b1;
    check_status("stall_status", 1'b0, 16'd100, 16'd0, 16'hFFFF);
  endtask

  task automatic test_corrupt;
    rand_ready = 1'b0; ready_i = 1'b1; corrupt_idx = 5;
    start_test(64'h200, 16'd10);
    run(100);
    corrupt_idx = -1;
    check_status("corrupt_status", 1'b0, 16'd10, 16'd1, 16'd5);
  endtask

  task automatic test_timeout;
    rand_ready = 1'b0; ready_i = 1'b1; drop_idx = 3;
    start_test(64'h300, 16'd4);
    run(200);
    drop_idx = -1;
    check_status("timeout_status", 1'b1, 16'd3, 16'd0, 16'hFFFF);
    // 16 idle cycles follow the third rx handshake; done_o is seen in the cycle after them.
    total++;
    if (rx_cyc.size() != 3 || done_cyc - rx_cyc[2] != TO + 1) begin
      bad++; $display("FAIL timeout_latency: rx_hs=%0d gap=%0d required 3 and %0d", rx_cyc.size(),
                      rx_cyc.size() == 3 ? done_cyc - rx_cyc[2] : -1, TO + 1);
    end
  endtask

  task automatic test_num_zero;
    bit saw_v;
    ready_i = 1'b1;
    start_test(64'h400, 16'd0);
    total++;
    if (done !== 1'b1 || v_o !== 1'b0) begin bad++; $display("FAIL zero_done: done=%b v=%b required 1 0", done, v_o); end
    saw_v = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (v_o !== 1'b0) saw_v = 1'b1; end
    total++;
    if (saw_v) begin bad++; $display("FAIL zero_no_valid: v_o=1 required 0"); end
    check_status("zero_status", 1'b0, 16'd0, 16'd0, 16'hFFFF);
  endtask

`ifdef BSG_CHIP_LINK_BIST_ERR_INJECT_EN
  task automatic test_inject;
    rand_ready = 1'b0; ready_i = 1'b1;
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    start_test(64'hFF, 16'd3);
    exp_q[0] = 64'hFE;
    run(100);
    check_status("inject_status", 1'b0, 16'd3, 16'd1, 16'd0);
  endtask
`endif

  task automatic test_reset_mid_run;
    rand_ready = 1'b0; ready_i = 1'b1;
    start_test(64'h55, 16'd50);
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1 || rx_count === '0) begin bad++; $display("FAIL pre_reset: busy=%b rx=%h required 1 nonzero", busy, rx_count); end
    rst_n = 1'b0;
    #1;
    test_reset();
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #22;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_loopback();
    test_back_to_back();
    test_stalls();
    test_corrupt();
    test_timeout();
    test_num_zero();
`ifdef BSG_CHIP_LINK_BIST_ERR_INJECT_EN
    test_inject();
`endif
    test_reset_mid_run();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
